// File: rtl/dual_ram_b_packer.sv
// Packs MULTNUM narrow stream words into one port-B write with enforced spacing.
// Optional write counter port: define DUAL_RAM_PACKER_WRCNT_EN.
module dual_ram_b_packer #(
    parameter int DWA        = 16,
    parameter int DWB        = 64,
    parameter int AWB        = 4,
    parameter int MULTNUM    = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clk_b,
    input  logic           rst_b,
    input  logic           i_start,
    input  logic [AWB-1:0] i_base_addr,
    input  logic [DWA-1:0] i_data,
    input  logic           i_valid,
    input  logic           i_last,
    output logic           o_ready,
    output logic [DWB-1:0] o_data_b,
    output logic [AWB-1:0] o_addr_b,
    output logic           o_wr_en_b,
    output logic           o_busy,
    output logic           o_frame_done
`ifdef DUAL_RAM_PACKER_WRCNT_EN
    ,output logic [15:0]   o_wr_count
`endif
);

    localparam int LW = (MULTNUM > 1) ? $clog2(MULTNUM) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(MULTNUM - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, PACK, WRITE, GAP} state_t;

    state_t         state, next_state;
    logic [AWB-1:0] addr;
    logic [DWB-1:0] pack, pack_next;
    logic [LW-1:0]  lane_cnt;
    logic [7:0]     gap_cnt;
    logic           last_seen;
    logic           xfer;

    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        xfer       = 1'b0;
        pack_next  = pack;
        unique case (state)
            IDLE: begin
                if (i_start) next_state = PACK;
            end
            PACK: begin
                if (i_valid) begin
                    xfer = 1'b1;
                    for (int k = 0; k < MULTNUM; k++)
                        if (lane_cnt == LW'(k))
                            pack_next[k*DWA +: DWA] = i_data;
                    if (lane_cnt == LAST_LANE || i_last)
                        next_state = WRITE;
                end
            end
            WRITE: begin
                if (HAS_GAP)        next_state = GAP;
                else if (last_seen) next_state = IDLE;
                else                next_state = PACK;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    next_state = last_seen ? IDLE : PACK;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state.
    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b) begin
            o_ready      <= 1'b0;
            o_busy       <= 1'b0;
            o_wr_en_b    <= 1'b0;
            o_frame_done <= 1'b0;
            o_data_b     <= '0;
            o_addr_b     <= '0;
            addr         <= '0;
            pack         <= '0;
            lane_cnt     <= '0;
            gap_cnt      <= '0;
            last_seen    <= 1'b0;
        end else begin
            o_ready      <= (next_state == PACK);
            o_busy       <= (next_state != IDLE);
            o_wr_en_b    <= (next_state == WRITE);
            o_frame_done <= (next_state == IDLE) && last_seen &&
                            (state == WRITE || state == GAP);
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        addr      <= i_base_addr;
                        pack      <= '0;
                        lane_cnt  <= '0;
                        last_seen <= 1'b0;
                    end
                end
                PACK: begin
                    if (xfer) begin
                        pack     <= pack_next;
                        lane_cnt <= lane_cnt + LW'(1);
                        if (i_last) last_seen <= 1'b1;
                        if (next_state == WRITE) begin
                            o_data_b <= pack_next;
                            o_addr_b <= addr;
                        end
                    end
                end
                WRITE: begin
                    addr     <= addr + AWB'(1);
                    pack     <= '0;
                    lane_cnt <= '0;
                    gap_cnt  <= '0;
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef DUAL_RAM_PACKER_WRCNT_EN
    always_ff @(posedge clk_b or posedge rst_b) begin
        if (rst_b)
            o_wr_count <= '0;
        else if (state == WRITE && o_wr_count != 16'hFFFF)
            o_wr_count <= o_wr_count + 16'd1;
    end
`endif

endmodule
